// File: rtl/whack_pkg.sv
// whack_pkg: shared states, mole codes and score deltas for the round scheduler
package whack_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHOW, GAP} state_t;
  localparam logic [2:0] BOMB = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [3:0] HOLE1 = 4'b1110;
  localparam logic [3:0] HOLE2 = 4'b1101;
  localparam logic [3:0] HOLE3 = 4'b1011;
  localparam logic [3:0] HOLE4 = 4'b0111;
  localparam logic [3:0] BLANK = 4'b1111;
  localparam logic [4:0] D_BOMB = 5'b11110;
  localparam logic [4:0] D_M1 = 5'd1;
  localparam logic [4:0] D_M2 = 5'd2;
  localparam logic [4:0] D_M3 = 5'd3;
  function automatic logic legal_pos(input logic [3:0] p);
    return p == HOLE1 || p == HOLE2 || p == HOLE3 || p == HOLE4;
  endfunction
  function automatic logic [4:0] delta_of(input logic [2:0] t);
    return t == M1 ? D_M1 : t == M2 ? D_M2 : t == M3 ? D_M3 : D_BOMB;
  endfunction
endpackage

// File: rtl/window_timer.sv
// window_timer: loadable down-counter that freezes on hold and flags zero
module window_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] count;
  // load wins; otherwise count down to zero and stay there
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (!hold && count != '0) count <= count - CNT_W'(1);
  end
  assign done = count == '0;
endmodule

// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: fetch, show and judge one mole per round
module mole_round_scheduler
  import whack_pkg::*;
#(
  parameter int CNT_W      = 28,
  parameter int SHOW_L1    = 125000000,
  parameter int SHOW_L2    = 80000000,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       RESTART,
  input  logic       pause,
  input  logic [3:0] level,
  input  logic       mole_ack,
  input  logic [3:0] mole_pos_in,
  input  logic [2:0] mole_type_in,
  input  logic [3:0] hit_pulse,
  output logic       mole_req,
  output logic [3:0] mole_anode,
  output logic [2:0] mole_type,
  output logic       mole_valid,
  output logic       score_valid,
  output logic [4:0] score_delta,
  output logic       miss_pulse
);
  state_t state;
  logic scoring, hit, load, done;
  logic [CNT_W-1:0] load_val;
  // hit match against the shown hole, timer reload on ack or round end, generator request
  always_comb begin
    hit = state == SHOW && scoring && |(hit_pulse & ~mole_anode);
    load = !pause && ((state == FETCH && mole_ack) || (state == SHOW && (hit || done)));
    load_val = state == FETCH ? (level <= 4'd1 ? CNT_W'(SHOW_L1 - 1) : CNT_W'(SHOW_L2 - 1))
                              : CNT_W'(GAP_CYCLES - 1);
    mole_req = state == FETCH && !pause;
  end
  window_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(RESTART),
    .load(load),
    .hold(pause),
    .load_val(load_val),
    .done(done)
  );
  // round FSM; pulses self-clear every cycle, everything else holds while paused
  always_ff @(posedge clk) begin
    if (RESTART) begin
      state <= IDLE;
      mole_anode <= BLANK;
      mole_type <= BOMB;
      mole_valid <= 1'b0;
      scoring <= 1'b0;
      score_valid <= 1'b0;
      score_delta <= '0;
      miss_pulse <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      score_delta <= '0;
      miss_pulse <= 1'b0;
      if (!pause) begin
        case (state)
          IDLE: state <= FETCH;
          FETCH: if (mole_ack) begin
            state <= SHOW;
            mole_anode <= mole_pos_in;
            mole_type <= mole_type_in;
            mole_valid <= 1'b1;
            scoring <= legal_pos(mole_pos_in) && !mole_type_in[2];
          end
          SHOW: if (hit || done) begin
            state <= GAP;
            mole_anode <= BLANK;
            mole_valid <= 1'b0;
            score_valid <= hit;
            score_delta <= hit ? delta_of(mole_type) : '0;
            miss_pulse <= !hit && scoring && mole_type != BOMB;
          end
          GAP: if (done) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb_mole_round_scheduler: directed checks of the mole round scheduler
module tb_mole_round_scheduler;
  logic clk = 1'b0;
  logic RESTART = 1'b1;
  logic pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic mole_ack = 1'b0;
  logic [3:0] mole_pos_in = 4'b1111;
  logic [2:0] mole_type_in = 3'd0;
  logic [3:0] hit_pulse = 4'd0;
  logic mole_req, mole_valid, score_valid, miss_pulse;
  logic [3:0] mole_anode;
  logic [2:0] mole_type;
  logic [4:0] score_delta;
  int n_chk = 0;
  int n_err = 0;
  int cnt, ev;

  mole_round_scheduler #(.CNT_W(28), .SHOW_L1(8), .SHOW_L2(4), .GAP_CYCLES(2)) dut (
    .clk(clk),
    .RESTART(RESTART),
    .pause(pause),
    .level(level),
    .mole_ack(mole_ack),
    .mole_pos_in(mole_pos_in),
    .mole_type_in(mole_type_in),
    .hit_pulse(hit_pulse),
    .mole_req(mole_req),
    .mole_anode(mole_anode),
    .mole_type(mole_type),
    .mole_valid(mole_valid),
    .score_valid(score_valid),
    .score_delta(score_delta),
    .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for a request, ack one mole, and land on the first SHOW cycle
  task automatic show(input logic [3:0] p, input logic [2:0] t);
    int w = 0;
    while (!mole_req && w < 20) begin
      step();
      w++;
    end
    chk("req_seen", mole_req, 1);
    mole_ack = 1'b1;
    mole_pos_in = p;
    mole_type_in = t;
    step();
    mole_ack = 1'b0;
    chk("shown_valid", mole_valid, 1);
    chk("shown_anode", mole_anode, p);
    chk("shown_type", mole_type, t);
  endtask

  // count SHOW cycles with no hits; stop on the first cycle the mole is gone
  task automatic run_out();
    cnt = 0;
    ev = 0;
    while (mole_valid && cnt < 40) begin
      cnt++;
      step();
      if (score_valid) ev++;
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_req", mole_req, 0);
    chk("rst_anode", mole_anode, 4'b1111);
    chk("rst_type", mole_type, 0);
    chk("rst_valid", mole_valid, 0);
    chk("rst_score", score_valid, 0);
    chk("rst_delta", score_delta, 0);
    chk("rst_miss", miss_pulse, 0);
    RESTART = 1'b0;
    step();
    chk("s1_req_after_release", mole_req, 1);
    // 1: type 1 at 1101 hit on 3rd SHOW cycle
    show(4'b1101, 3'd1);
    step();
    step();
    hit_pulse = 4'b0010;
    step();
    hit_pulse = 4'b0000;
    chk("s1_score", score_valid, 1);
    chk("s1_delta", score_delta, 5'd1);
    chk("s1_blank", mole_anode, 4'b1111);
    chk("s1_miss", miss_pulse, 0);
    chk("s1_gap1_req", mole_req, 0);
    step();
    chk("s1_score_1cyc", score_valid, 0);
    chk("s1_gap2_req", mole_req, 0);
    step();
    chk("s1_fetch_req", mole_req, 1);
    // 2: bomb at 0111
    show(4'b0111, 3'd0);
    hit_pulse = 4'b1000;
    step();
    hit_pulse = 4'b0000;
    chk("s2_score", score_valid, 1);
    chk("s2_delta", score_delta, 5'b11110);
    chk("s2_miss", miss_pulse, 0);
    step();
    chk("s2_score_1cyc", score_valid, 0);
    chk("s2_delta_clr", score_delta, 0);
    chk("s2_miss_after", miss_pulse, 0);
    // 3: type 2 expires unhit
    show(4'b1011, 3'd2);
    run_out();
    chk("s3_len", cnt, 8);
    chk("s3_events", ev, 0);
    chk("s3_miss", miss_pulse, 1);
    chk("s3_score", score_valid, 0);
    step();
    chk("s3_miss_1cyc", miss_pulse, 0);
    // 4a: wrong hole ignored, then two bits give one event
    show(4'b1101, 3'd3);
    hit_pulse = 4'b0001;
    step();
    chk("s4_wrong_score", score_valid, 0);
    chk("s4_wrong_valid", mole_valid, 1);
    hit_pulse = 4'b0011;
    step();
    hit_pulse = 4'b0000;
    chk("s4_score", score_valid, 1);
    chk("s4_delta", score_delta, 5'd3);
    step();
    chk("s4_single", score_valid, 0);
    // 4b: hit on the last SHOW cycle beats expiry
    show(4'b1110, 3'd2);
    for (int i = 0; i < 7; i++) step();
    chk("s4_last_valid", mole_valid, 1);
    hit_pulse = 4'b0001;
    step();
    hit_pulse = 4'b0000;
    chk("s4_last_score", score_valid, 1);
    chk("s4_last_delta", score_delta, 5'd2);
    chk("s4_last_miss", miss_pulse, 0);
    step();
    chk("s4_last_miss_after", miss_pulse, 0);
    // 4c: illegal position is shown but neither scores nor misses
    show(4'b1001, 3'd2);
    hit_pulse = 4'b0110;
    step();
    hit_pulse = 4'b0000;
    chk("s4_bad_score", score_valid, 0);
    run_out();
    chk("s4_bad_len", cnt, 7);
    chk("s4_bad_miss", miss_pulse, 0);
    // 5: pause mid-SHOW
    show(4'b1101, 3'd1);
    cnt = 0;
    ev = 0;
    for (int c = 0; c < 40 && mole_valid; c++) begin
      cnt++;
      pause = (c >= 2 && c < 7);
      hit_pulse = pause ? 4'b0010 : 4'b0000;
      step();
      if (score_valid) ev++;
    end
    pause = 1'b0;
    hit_pulse = 4'b0000;
    chk("s5_len", cnt, 13);
    chk("s5_events", ev, 0);
    chk("s5_miss", miss_pulse, 1);
    step();
    step();
    chk("s5_fetch_req", mole_req, 1);
    pause = 1'b1;
    mole_ack = 1'b1;
    mole_pos_in = 4'b1110;
    mole_type_in = 3'd1;
    #1;
    chk("s5_req_paused", mole_req, 0);
    step();
    step();
    chk("s5_ack_ignored", mole_valid, 0);
    chk("s5_req_still", mole_req, 0);
    mole_ack = 1'b0;
    pause = 1'b0;
    #1;
    chk("s5_req_resume", mole_req, 1);
    // 6: level 2 window, then restart mid-SHOW
    level = 4'd2;
    show(4'b0111, 3'd1);
    run_out();
    chk("s6_len", cnt, 4);
    chk("s6_miss", miss_pulse, 1);
    show(4'b1011, 3'd2);
    step();
    RESTART = 1'b1;
    step();
    chk("s6_rst_anode", mole_anode, 4'b1111);
    chk("s6_rst_valid", mole_valid, 0);
    chk("s6_rst_req", mole_req, 0);
    chk("s6_rst_type", mole_type, 0);
    chk("s6_rst_score", score_valid, 0);
    chk("s6_rst_delta", score_delta, 0);
    chk("s6_rst_miss", miss_pulse, 0);
    RESTART = 1'b0;
    chk("s6_idle_req", mole_req, 0);
    step();
    chk("s6_req_after", mole_req, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
Sequences one mole "round" at a time for the whack-a-mole game. It requests a mole (position and type) from the mole generator, shows it for a level-dependent window, and judges button hits against the shown position. It emits one signed score event per round, or a miss pulse.
- Sits between mole_generator, the debounced hit inputs, and the score/level logic in mastergame.
- Replaces the free-running frequency counters with a handshaked round FSM.

Parameters:
CNT_W, 28, width of window counter
SHOW_L1, 125000000, show-window length in clk cycles for level 0/1
SHOW_L2, 80000000, show-window length for level >= 2
GAP_CYCLES, 25000000, blank interval between rounds

Ports:
clk  in  1  system clock
RESTART  in  1  synchronous active-high reset
pause  in  1  SWITCH; freezes the scheduler while high
level  in  4  current game level
mole_ack  in  1  generator has valid pos/type this cycle
mole_pos_in  in  4  anode code from generator, active-low one-cold (1110, 1101, 1011, 0111)
mole_type_in  in  3  mole type from generator
hit_pulse  in  4  single-cycle debounced hits; bit0 = hole 1110 ... bit3 = hole 0111
mole_req  out  1  request a new mole
mole_anode  out  4  position shown; 1111 = none
mole_type  out  3  latched type of the shown mole
mole_valid  out  1  a mole is currently shown
score_valid  out  1  one-cycle score event
score_delta  out  5  signed two's-complement delta
miss_pulse  out  1  one-cycle: a scoring mole expired unhit

Behaviour:
- Reset (sync, RESTART=1 at a clk edge) takes priority over everything, including mid-round. All outputs next cycle: mole_req=0, mole_anode=1111, mole_type=0, mole_valid=0, score_valid=0, score_delta=0, miss_pulse=0. State goes to IDLE and the counter to 0.
- States: IDLE, FETCH, SHOW, GAP.
- IDLE -> FETCH on the first cycle with pause=0.
- FETCH:
  - mole_req=1 while pause=0.
  - On mole_ack=1: latch pos/type, load counter = window-1, go to SHOW.
  - window = SHOW_L1 if level<=1, else SHOW_L2. Level is sampled only at load; a level change mid-round takes effect next round.
  - mole_pos_in not one of the four legal codes is treated as an invalid mole.
- SHOW:
  - mole_anode = latched pos, mole_valid=1.
  - Hit match: any hit_pulse bit i set whose hole equals the latched pos. Multiple bits in one cycle give at most one event. Non-matching bits are ignored (no penalty).
  - On match: score_valid=1 next cycle. Delta by type: 0 -> -2 (11110), 1 -> +1, 2 -> +2, 3 -> +3. Then mole_anode=1111, mole_valid=0, go to GAP.
  - Types 4..7 or an invalid pos: hits are ignored, there is no event and no miss pulse, but the window still runs.
  - Counter reaching 0 with no hit: miss_pulse=1 next cycle if type is 1..3, then go to GAP. Type 0 expiring produces no pulse.
  - A hit on the final SHOW cycle beats expiry (score, not miss).
  - SHOW lasts exactly window cycles.
- GAP: mole_anode=1111, counts GAP_CYCLES cycles, then goes to FETCH.
- Pause=1:
  - State, counter and all latched values hold.
  - mole_req is forced 0.
  - hit_pulse and mole_ack are ignored.
  - The display outputs hold.
  - score_valid and miss_pulse stay 0.
- Latency: hit at cycle t -> score_valid at t+1. score_valid and miss_pulse are never high together, and each is exactly 1 cycle wide.
- Counter arithmetic is unsigned CNT_W. There is no wrap: it is loaded only with window-1 or GAP_CYCLES-1.

Decomposition:
- Package whack_pkg:
  - state enum (IDLE/FETCH/SHOW/GAP)
  - mole type constants (BOMB=0, M1=1, M2=2, M3=3)
  - anode codes (HOLE1..HOLE4, BLANK=1111)
  - score delta constants
- One sub-module, window_timer: loadable down-counter with hold (pause) and done flag, parameter CNT_W.

Test Plan:
All scenarios use SHOW_L1=8, SHOW_L2=4, GAP_CYCLES=2.
1. Reset, then ack pos=1101 type=1; hit_pulse=0010 on 3rd SHOW cycle -> next cycle score_valid=1, score_delta=+1, mole_anode=1111; FETCH again after exactly 2 GAP cycles.
2. Type 0 at pos 0111, hit_pulse=1000 -> score_delta=5'b11110 for 1 cycle, no miss_pulse.
3. Type 2, no hits -> mole_valid high exactly 8 cycles, then miss_pulse=1 for 1 cycle, score_valid stays 0.
4. Pos 1101 type 3: hit_pulse=0001 -> ignored, mole stays shown; later hit_pulse=0011 -> single event, delta=+3. Also: hit on the 8th (last) SHOW cycle -> score, no miss.
5. pause=1 for 5 cycles mid-SHOW with hit_pulse=0010 during pause -> no event, mole_valid high 13 cycles total, mole_req=0 while paused in FETCH.
6. level=2 -> SHOW lasts 4 cycles. RESTART=1 mid-SHOW -> next cycle mole_anode=1111, all outputs 0, state IDLE, then mole_req=1 one cycle after release.
